// File: rtl/source.sv
// Serial 3-bit pattern classifier: shifts x into a history window and reports
// runs of ones, 1-0-1 alternation or runs of zeros as a registered 2-bit code.
module source (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  output logic [1:0] y
);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_ALT   = 2'b01;
  localparam logic [1:0] CODE_ONES  = 2'b10;
  localparam logic [1:0] CODE_ZEROS = 2'b11;

  logic [2:0] hist_q, hist_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] y_q, y_d;

  always_comb begin
    hist_d = {hist_q[1:0], x};
    cnt_d  = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
    y_d    = CODE_NONE;
    // Classify only once the window holds three real samples since reset.
    if (cnt_d == 2'd3) begin
      case (hist_d)
        3'b111:  y_d = CODE_ONES;
        3'b101:  y_d = CODE_ALT;
        3'b000:  y_d = CODE_ZEROS;
        default: y_d = CODE_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= 3'b000;
      cnt_q  <= 2'd0;
      y_q    <= CODE_NONE;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_source.sv
// Directed bench for the serial pattern classifier: hand-computed codes per sample.
module tb_source;

  logic       clk;
  logic       rst;
  logic       x;
  logic [1:0] y;

  int n_cmp;
  int n_err;

  source dut (
    .clk(clk),
    .rst(rst),
    .x  (x),
    .y  (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: y=%b expected %b", tag, got, exp);
    end else begin
      $display("ok   %s: y=%b", tag, got);
    end
  endtask

  // Called at a falling edge; drives one bit, checks y just after the rising edge,
  // and returns at the next falling edge.
  task automatic step(input string tag, input logic b, input logic [1:0] exp);
    x = b;
    @(posedge clk);
    #1;
    check_val(tag, y, exp);
    @(negedge clk);
  endtask

  // Called at a falling edge; pulses reset across one rising edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check_val({tag, "_async"}, y, 2'b00);
    x = 1'b1;
    @(posedge clk);
    #1;
    check_val({tag, "_held"}, y, 2'b00);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic       seq_x   [20];
  logic [1:0] seq_exp [20];

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    x     = 1'b0;

    seq_x   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    seq_exp = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10,
                2'b00, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11};

    // Reset held while x toggles.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      x = i[0];
      @(posedge clk);
      #1;
      check_val($sformatf("reset_hold_%0d", i), y, 2'b00);
      @(negedge clk);
    end
    rst = 1'b1;

    // Fill with ones.
    step("fill_1", 1'b1, 2'b00);
    step("fill_2", 1'b1, 2'b00);
    step("fill_3", 1'b1, 2'b10);

    // Mid-run reset: y drops asynchronously, history is discarded.
    do_reset("midrun_rst");
    step("refill_1", 1'b1, 2'b00);
    step("refill_2", 1'b1, 2'b00);
    step("refill_3", 1'b1, 2'b10);

    // Full directed sequence.
    do_reset("seq_rst");
    for (int i = 0; i < 20; i++)
      step($sformatf("seq_%0d", i + 1), seq_x[i], seq_exp[i]);

    // Overlapping alternation.
    do_reset("alt_rst");
    step("alt_1", 1'b1, 2'b00);
    step("alt_2", 1'b0, 2'b00);
    step("alt_3", 1'b1, 2'b01);
    step("alt_4", 1'b0, 2'b00);
    step("alt_5", 1'b1, 2'b01);

    // Zero run must not count reset content as zeros.
    do_reset("zero_rst");
    step("zero_1", 1'b0, 2'b00);
    step("zero_2", 1'b0, 2'b00);
    step("zero_3", 1'b0, 2'b11);
    step("zero_4", 1'b0, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/source.md
# source

Registered Moore-style pattern classifier on a 1-bit serial input. Each rising clock edge samples `x` into a three-bit history window. A 2-bit code on `y` reports whether the window currently holds a run of three ones, the pattern 1-0-1, or a run of three zeros. The block is a standalone control-path FSM that downstream logic reads once per clock.

## Interface
- No parameters.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset. `rst`=0 clears all state immediately, independent of `clk`.
- `x`  input  1  serial data bit, sampled on each rising `clk` edge while `rst`=1.
- `y`  output  2  classification code, driven from registers (no combinational path from `x`).

## Operation
- **History window.** The internal history is h2 h1 h0, where h0 is the most recently sampled bit.
- **Sample counter.** A fill counter `cnt` saturates at 3.
- **Each rising edge with `rst`=1:**
  - h2 ← h1, h1 ← h0, h0 ← `x`.
  - `cnt` ← min(`cnt`+1, 3).
  - `y` ← code(new window).
- **Code rule**, evaluated only when `cnt` = 3 after the update:
  - 1,1,1 → `y` = 2'b10 (run of ones)
  - 1,0,1 → `y` = 2'b01 (alternation)
  - 0,0,0 → `y` = 2'b11 (run of zeros)
  - any other window → `y` = 2'b00
- **Filling.** While fewer than 3 bits have been sampled since reset, `y` = 2'b00 regardless of bit values. Reset content never counts as zeros.
- **Overlap.** Windows overlap fully, so consecutive matches are each reported. For example, input 1,1,1,1 yields `y` = 10 on the 3rd and 4th samples.
- **Implementation form.** The design may be an explicit FSM: states RST, S0, S1, S00, S01, S10, S11, then steady states keyed by the 3-bit window. It may instead be a shift register plus counter. Externally visible behaviour must be identical.
- **Reset.** While `rst`=0:
  - h2, h1, h0 = 0, `cnt` = 0, `y` = 2'b00.
  - Asserting `rst` mid-stream discards all history. The next three samples after release refill the window before any nonzero code appears.
- **No unused states.** There are no illegal states. Any unreachable FSM encoding returns to RST on the next edge.

## Timing
- **Latency.** `y` changes only on a rising `clk` edge, or asynchronously to 00 on `rst` falling. The code for a window appears immediately after the edge that samples that window's newest bit: 1-cycle registered latency from `x`.
- **Input stability.** `x` must be stable around the rising edge (setup/hold). Changes between edges have no effect.
- **First sample after release.** The first rising edge with `rst`=1 samples bit 1.
- **Earliest nonzero `y`.** This is after the 3rd such edge.
- **Reset release.** Deassertion of `rst` between edges is safe; the first sample is taken at the next rising edge.
- **Reset asserted at a clock edge.** If `rst` goes low coincident with a rising edge, reset wins: `y` = 00 and the history is cleared.

## Test plan
- **Reset.**
  - Stimulus: hold `rst`=0 for several cycles while toggling `x`, then pull `rst` low mid-stream.
  - Required: `y` = 00 throughout reset, and `y` drops to 00 asynchronously, before the next edge.
- **Fill.**
  - Stimulus: release reset, then x = 1,1.
  - Required: `y` = 00 after each of the first two edges.
  - Stimulus: third bit x = 1.
  - Required: `y` = 10.
- **Full sequence.**
  - Stimulus: after reset, x = 0,1,0,1,1,0,0,1,1,1,0,1,1,1,1,0,0,0,0,0, one bit per cycle.
  - Required `y` after samples 1–20: 00,00,00,01,00,00,00,00,00,10,00,01,00,10,10,00,00,11,11,11.
- **Overlapping alternation.**
  - Stimulus: x = 1,0,1,0,1.
  - Required: `y` = 01 after samples 3 and 5, and 00 after sample 4 (window 0,1,0).
- **Reset mid-run.**
  - Stimulus: x = 1,1,1 giving `y`=10; pulse `rst` low; then x = 1,1.
  - Required: `y` = 00 during and after the pulse until a 3rd post-reset 1 is sampled, then `y` = 10.
- **Zero-run qualification.**
  - Stimulus: release reset, then x = 0,0.
  - Required: `y` = 00 after both samples (reset history is not counted).
  - Stimulus: third bit x = 0.
  - Required: `y` = 11.
